ctrl_pipe_reg: RTL and testbench

Parametrised pipeline register for decoded control bundles between CPU pipeline stages, e.g. decode→execute and execute→memory/writeback. It carries a WIDTH-bit control word plus a valid bit through DEPTH register stages. Stall holds every stage. Flush squashes every stage and forces side-effect bits to zero so no register, memory or CSR write escapes. Optional saturating performance counters report stall cycles, flushes and bubbles.

---
 rtl/ctrl_pipe_reg.sv | 103 ++++++++++
 tb/tb_ctrl_pipe_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_reg.sv
// Pipeline register for decoded control bundles: DEPTH stages of {valid, ctrl}
// with stall/flush. Define CTRL_PIPE_PERF_EN to build saturating perf counters.
module ctrl_pipe_reg #(
   parameter int unsigned          WIDTH     = 16,
   parameter int unsigned          DEPTH     = 1,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0,
   parameter logic [WIDTH-1:0]     KILL_MASK = '1,
   localparam int unsigned         OCC_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_ctrl,
   output logic [OCC_W-1:0]  occupancy,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
   output logic [31:0]       bubble_cnt
);

   generate
      if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
         $error("ctrl_pipe_reg: DEPTH must be in 1..4");
      end
      if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
         $error("ctrl_pipe_reg: WIDTH must be in 1..64");
      end
   endgenerate

   logic [DEPTH-1:0]            v_q, v_d;
   logic [DEPTH-1:0][WIDTH-1:0] c_q, c_d;

   always_comb begin
      v_d = v_q;
      c_d = c_q;
      if (flush) begin
         // Squash: drop valids and clear write-enable bits, keep the rest for debug.
         v_d = '0;
         for (int k = 0; k < DEPTH; k++) c_d[k] = c_q[k] & ~KILL_MASK;
      end else if (!stall) begin
         v_d[0] = in_valid;
         c_d[0] = in_valid ? in_ctrl : RESET_VAL;
         for (int k = 1; k < DEPTH; k++) begin
            v_d[k] = v_q[k-1];
            c_d[k] = c_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_q <= '0;
         c_q <= {DEPTH{RESET_VAL}};
      end else begin
         v_q <= v_d;
         c_q <= c_d;
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_ctrl  = c_q[DEPTH-1];

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(v_q[k]);
   end

`ifdef CTRL_PIPE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Saturate at all-ones rather than wrapping.
   assign stall_cnt_d  = (stall && !flush && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   assign flush_cnt_d  = (flush && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
   assign bubble_cnt_d = (!stall && !flush && !out_valid && bubble_cnt_q != '1)
                         ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = 32'h0;
   assign flush_cnt  = 32'h0;
   assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Directed bench for ctrl_pipe_reg (DEPTH=2, KILL_MASK=16'h000F); works with or
// without CTRL_PIPE_PERF_EN.
module tb_ctrl_pipe_reg;

`ifdef CTRL_PIPE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_ctrl;
   logic        stall;
   logic        flush;
   logic        out_valid;
   logic [15:0] out_ctrl;
   logic [1:0]  occupancy;
   logic [31:0] stall_cnt, flush_cnt, bubble_cnt;

   int n_cmp = 0;
   int n_err = 0;

   ctrl_pipe_reg #(
      .WIDTH(16), .DEPTH(2), .RESET_VAL(16'h0000), .KILL_MASK(16'h000F)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
      .stall(stall), .flush(flush), .out_valid(out_valid), .out_ctrl(out_ctrl),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] ic;
      logic        st;
      logic        fl;
      logic        ev;
      logic [15:0] ec;
      logic [1:0]  eo;
      int          es;
      int          ef;
      int          eb;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pc(input int n);
      return PERF ? 32'(n) : 32'h0;
   endfunction

   task automatic check_all(input string tag, input logic ev, input logic [15:0] ec,
                            input logic [1:0] eo, input int es, input int ef, input int eb);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".out_ctrl"}, 32'(out_ctrl), 32'(ec));
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(eo));
      chk({tag, ".stall_cnt"}, stall_cnt, pc(es));
      chk({tag, ".flush_cnt"}, flush_cnt, pc(ef));
      chk({tag, ".bubble_cnt"}, bubble_cnt, pc(eb));
   endtask

   initial begin
      //            iv  ic        st  fl  ev  ec        eo  es ef eb
      vecs[0]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 0, 0, 1};
      vecs[1]  = '{1'b1, 16'hA002, 1'b0, 1'b0, 1'b1, 16'hA001, 2'd2, 0, 0, 2};
      vecs[2]  = '{1'b1, 16'hA003, 1'b0, 1'b0, 1'b1, 16'hA002, 2'd2, 0, 0, 2};
      vecs[3]  = '{1'b1, 16'hA004, 1'b1, 1'b0, 1'b1, 16'hA002, 2'd2, 1, 0, 2};
      vecs[4]  = '{1'b1, 16'hA004, 1'b1, 1'b0, 1'b1, 16'hA002, 2'd2, 2, 0, 2};
      vecs[5]  = '{1'b1, 16'hA004, 1'b1, 1'b0, 1'b1, 16'hA002, 2'd2, 3, 0, 2};
      vecs[6]  = '{1'b1, 16'hA004, 1'b0, 1'b0, 1'b1, 16'hA003, 2'd2, 3, 0, 2};
      vecs[7]  = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hA004, 2'd1, 3, 0, 2};
      vecs[8]  = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 3, 0, 2};
      vecs[9]  = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 3, 0, 3};
      vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 2'd1, 3, 0, 4};
      // flush with a valid input: BEEF loses its low nibble, 1111 dropped
      vecs[11] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'hBEE0, 2'd0, 3, 1, 4};
      vecs[12] = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 3, 1, 5};
      // flush + stall: flush wins, 1234 dropped, stall_cnt unchanged
      vecs[13] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 3, 2, 5};
      vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5550, 2'd0, 3, 2, 6};
      vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 3, 2, 7};

      reset = 1'b0; in_valid = 1'b0; in_ctrl = 16'h0; stall = 1'b0; flush = 1'b0;
      #2;
      check_all("async_reset", 1'b0, 16'h0000, 2'd0, 0, 0, 0);
      #5 reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         in_valid = vecs[i].iv; in_ctrl = vecs[i].ic;
         stall = vecs[i].st; flush = vecs[i].fl;
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].eo,
                   vecs[i].es, vecs[i].ef, vecs[i].eb);
         chk($sformatf("vec%0d.no1234", i), 32'(out_ctrl == 16'h1234), 32'd0);
      end

      // reset asserted in the middle of a stall
      in_valid = 1'b1; in_ctrl = 16'hC001; stall = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      in_ctrl = 16'hC002;
      @(posedge clk); #1;
      chk("prefill.out_ctrl", 32'(out_ctrl), 32'h0000C001);
      stall = 1'b1;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check_all("midstall_reset", 1'b0, 16'h0000, 2'd0, 0, 0, 0);
      #1 reset = 1'b1;

      // saturation: preload stall counter just below all-ones
`ifdef CTRL_PIPE_PERF_EN
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.stall_cnt_q;
`endif
      in_valid = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("sat%0d.stall_cnt", i), stall_cnt, PERF ? 32'hFFFF_FFFF : 32'h0);
         chk($sformatf("sat%0d.bubble_cnt", i), bubble_cnt, 32'h0);
      end
      stall = 1'b0;
      @(posedge clk); #1;
      chk("post_sat.stall_cnt", stall_cnt, PERF ? 32'hFFFF_FFFF : 32'h0);
      chk("post_sat.bubble_cnt", bubble_cnt, pc(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
